// File: rtl/maxpool_stream.sv
// ============================================================================
// maxpool_stream
// ----------------------------------------------------------------------------
// Streaming 2x2 / stride-2 max pooling over a raster-ordered feature map.
// Each input beat carries one pixel with CHANNELS values packed side by side;
// each output beat carries one pooled pixel with the same packing.
//
// Datapath:
//   even column        -> pixel parked in the horizontal-hold register
//   odd col, even row  -> max(hold, pixel) written to line buffer [col/2]
//   odd col, odd row   -> max(linebuf[col/2], hold, pixel) loaded into the
//                         single-entry output register (one cycle latency)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_data    in   CHANNELS*BITWIDTH, channel c at [c*BITWIDTH +: BITWIDTH]
//   in_valid   in   in_data is valid
//   in_ready   out  beat accepted when in_valid && in_ready
//   out_data   out  pooled pixel, same packing as in_data
//   out_valid  out  out_data is valid
//   out_ready  in   downstream accepts out_data
//   out_last   out  out_data is the final pooled pixel of the frame
// ============================================================================
module maxpool_stream #(
    parameter int BITWIDTH    = 32,
    parameter int CHANNELS    = 2,
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int SIGNED_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*BITWIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [CHANNELS*BITWIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last
);

    localparam int DW = CHANNELS * BITWIDTH;
    localparam int HW = IMG_W / 2;
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LW = (HW > 1) ? $clog2(HW) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    generate
        if ((IMG_W % 2) != 0 || IMG_W < 2 || (IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_dims
            $error("maxpool_stream: IMG_W and IMG_H must be even and >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Compare helpers
    // ------------------------------------------------------------------------
    function automatic logic [BITWIDTH-1:0] max1(input logic [BITWIDTH-1:0] a,
                                                 input logic [BITWIDTH-1:0] b);
        logic signed [BITWIDTH-1:0] sa;
        logic signed [BITWIDTH-1:0] sb;
        logic                       a_gt;
        sa = a;
        sb = b;
        if (SIGNED_MODE != 0) a_gt = (sa > sb);
        else                  a_gt = (a > b);
        // Ties pick b, which equals a, so the value is unchanged either way.
        return a_gt ? a : b;
    endfunction

    function automatic logic [DW-1:0] vmax(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            r[c*BITWIDTH +: BITWIDTH] = max1(a[c*BITWIDTH +: BITWIDTH],
                                             b[c*BITWIDTH +: BITWIDTH]);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CW-1:0] col_q,       col_d;
    logic [RW-1:0] row_q,       row_d;
    logic [DW-1:0] hold_q,      hold_d;
    logic [DW-1:0] out_data_q,  out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q,  out_last_d;

    // Line buffer is never reset: every entry is written on an even row
    // before the following odd row reads it.
    logic [DW-1:0] lb_q [HW];

    logic          accept;
    logic          lb_we;
    logic [LW-1:0] lb_idx;
    logic [DW-1:0] h_max;
    logic [DW-1:0] v_max;

    // The output register can take a new value whenever it is empty or being
    // drained this cycle, which gives full throughput with out_ready high.
    assign in_ready = !out_valid_q || out_ready;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        accept      = in_valid && in_ready;
        lb_idx      = LW'(col_q >> 1);
        h_max       = vmax(hold_q, in_data);
        v_max       = vmax(lb_q[lb_idx], h_max);

        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        lb_we       = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (!col_q[0]) begin
                hold_d = in_data;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                // A drain in the same cycle is overridden here, so a new
                // result replaces the old one without a bubble.
                out_data_d  = v_max;
                out_valid_d = 1'b1;
                out_last_d  = (col_q == COL_LAST) && (row_q == ROW_LAST);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lb_we) lb_q[lb_idx] <= h_max;
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed bench for maxpool_stream using several parameterisations that
// share one clock and one reset.
module tb_maxpool_stream;

    logic clk;
    logic rst;

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- A: 1 channel, 4x4, unsigned -------------------------------------
    logic [31:0] a_in_data, a_out_data;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [31:0] a_q [$];
    bit          a_lq[$];

    maxpool_stream #(.BITWIDTH(32), .CHANNELS(1), .IMG_W(4), .IMG_H(4), .SIGNED_MODE(0)) dut_a (
        .clk(clk), .rst(rst),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_last(a_out_last));

    // ---- S/U: 1 channel, 2x2, signed and unsigned, shared stimulus --------
    logic [31:0] s_in_data, s_out_data, u_out_data;
    logic        s_in_valid, s_out_ready;
    logic        s_in_ready, s_out_valid, s_out_last;
    logic        u_in_ready, u_out_valid, u_out_last;
    logic [31:0] s_q [$];
    logic [31:0] u_q [$];

    maxpool_stream #(.BITWIDTH(32), .CHANNELS(1), .IMG_W(2), .IMG_H(2), .SIGNED_MODE(1)) dut_s (
        .clk(clk), .rst(rst),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_last(s_out_last));

    maxpool_stream #(.BITWIDTH(32), .CHANNELS(1), .IMG_W(2), .IMG_H(2), .SIGNED_MODE(0)) dut_u (
        .clk(clk), .rst(rst),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(u_in_ready),
        .out_data(u_out_data), .out_valid(u_out_valid), .out_ready(s_out_ready),
        .out_last(u_out_last));

    // ---- M: 2 channels x 8 bits, 2x2, unsigned ----------------------------
    logic [15:0] m_in_data, m_out_data;
    logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_last;
    logic [15:0] m_q [$];
    bit          m_lq[$];

    maxpool_stream #(.BITWIDTH(8), .CHANNELS(2), .IMG_W(2), .IMG_H(2), .SIGNED_MODE(0)) dut_m (
        .clk(clk), .rst(rst),
        .in_data(m_in_data), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .out_data(m_out_data), .out_valid(m_out_valid), .out_ready(m_out_ready),
        .out_last(m_out_last));

    // ---- B: default parameters (32 bit, 2 channels, 28x28) ----------------
    logic [63:0] b_in_data, b_out_data;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [63:0] b_q [$];
    bit          b_lq[$];

    maxpool_stream dut_b (
        .clk(clk), .rst(rst),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_last(b_out_last));

    // Output monitors: sampled on the falling edge, each recorded beat is the
    // transfer that completes on the following rising edge.
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin a_q.push_back(a_out_data); a_lq.push_back(a_out_last); end
        if (!rst && s_out_valid && s_out_ready) s_q.push_back(s_out_data);
        if (!rst && u_out_valid && s_out_ready) u_q.push_back(u_out_data);
        if (!rst && m_out_valid && m_out_ready) begin m_q.push_back(m_out_data); m_lq.push_back(m_out_last); end
        if (!rst && b_out_valid && b_out_ready) begin b_q.push_back(b_out_data); b_lq.push_back(b_out_last); end
    end

    localparam logic [31:0] RAMP_EXP [4] = '{32'd5, 32'd7, 32'd13, 32'd15};

    // ---- beat drivers (called at posedge+1, return at posedge+1) ----------
    task automatic a_send(input logic [31:0] v);
        int n;
        n = 0;
        a_in_data  = v;
        a_in_valid = 1'b1;
        @(negedge clk);
        while (!a_in_ready && n < 200) begin @(negedge clk); n++; end
        if (!a_in_ready) begin
            checks++; errors++;
            $display("FAIL a_send_timeout in_ready got %0b want 1", a_in_ready);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic s_send(input logic [31:0] v);
        int n;
        n = 0;
        s_in_data  = v;
        s_in_valid = 1'b1;
        @(negedge clk);
        while (!s_in_ready && n < 200) begin @(negedge clk); n++; end
        if (!s_in_ready) begin
            checks++; errors++;
            $display("FAIL s_send_timeout in_ready got %0b want 1", s_in_ready);
        end
        @(posedge clk); #1;
        s_in_valid = 1'b0;
    endtask

    task automatic m_send(input logic [15:0] v);
        int n;
        n = 0;
        m_in_data  = v;
        m_in_valid = 1'b1;
        @(negedge clk);
        while (!m_in_ready && n < 200) begin @(negedge clk); n++; end
        if (!m_in_ready) begin
            checks++; errors++;
            $display("FAIL m_send_timeout in_ready got %0b want 1", m_in_ready);
        end
        @(posedge clk); #1;
        m_in_valid = 1'b0;
    endtask

    task automatic b_send(input logic [63:0] v);
        int n;
        n = 0;
        b_in_data  = v;
        b_in_valid = 1'b1;
        @(negedge clk);
        while (!b_in_ready && n < 200) begin @(negedge clk); n++; end
        if (!b_in_ready) begin
            checks++; errors++;
            $display("FAIL b_send_timeout in_ready got %0b want 1", b_in_ready);
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    // ---- scenarios --------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", a_out_valid); end
        checks++;
        if (a_out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %0b want 0", a_out_last); end
        checks++;
        if (a_out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got %h want 0", a_out_data); end
        checks++;
        if (b_out_data !== 64'd0 || b_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_b_out got %h/%0b want 0/0", b_out_data, b_out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", a_in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        a_q.delete(); a_lq.delete();
        for (int k = 0; k < 16; k++) a_send(32'(k));
        repeat (3) @(posedge clk); #1;
        checks++;
        if (a_q.size() != 4) begin errors++; $display("FAIL ramp_count got %0d want 4", a_q.size()); end
        for (int i = 0; i < 4 && i < a_q.size(); i++) begin
            checks++;
            if (a_q[i] !== RAMP_EXP[i]) begin errors++; $display("FAIL ramp_data[%0d] got %0d want %0d", i, a_q[i], RAMP_EXP[i]); end
            checks++;
            if (a_lq[i] !== (i == 3)) begin errors++; $display("FAIL ramp_last[%0d] got %0b want %0b", i, a_lq[i], (i == 3)); end
        end
    endtask

    task automatic test_gaps();
        a_q.delete(); a_lq.delete();
        for (int k = 0; k < 16; k++) begin
            a_send(32'(k));
            a_in_data = 32'hDEAD_0000 + 32'(k);
            repeat (2) @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (a_q.size() != 4) begin errors++; $display("FAIL gaps_count got %0d want 4", a_q.size()); end
        for (int i = 0; i < 4 && i < a_q.size(); i++) begin
            checks++;
            if (a_q[i] !== RAMP_EXP[i] || a_lq[i] !== (i == 3)) begin
                errors++; $display("FAIL gaps_data[%0d] got %0d/%0b want %0d/%0b", i, a_q[i], a_lq[i], RAMP_EXP[i], (i == 3));
            end
        end
    endtask

    task automatic test_signed();
        s_q.delete(); u_q.delete();
        s_send(32'hFFFF_FFFF); s_send(32'hFFFF_FFFB); s_send(32'hFFFF_FFFD); s_send(32'hFFFF_FFFE);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (s_q.size() != 1 || s_q[0] !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL signed_neg got %0d beats first %h want 1 beat ffffffff", s_q.size(), (s_q.size() > 0) ? s_q[0] : 32'hx);
        end
        checks++;
        if (u_q.size() != 1 || u_q[0] !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL unsigned_neg got %0d beats first %h want 1 beat ffffffff", u_q.size(), (u_q.size() > 0) ? u_q[0] : 32'hx);
        end
        s_q.delete(); u_q.delete();
        s_send(32'hFFFF_FFFB); s_send(32'd3); s_send(32'hFFFF_FFFE); s_send(32'd1);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (s_q.size() != 1 || s_q[0] !== 32'd3) begin
            errors++; $display("FAIL signed_mix got %0d beats first %h want 1 beat 00000003", s_q.size(), (s_q.size() > 0) ? s_q[0] : 32'hx);
        end
        checks++;
        if (u_q.size() != 1 || u_q[0] !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL unsigned_mix got %0d beats first %h want 1 beat fffffffe", u_q.size(), (u_q.size() > 0) ? u_q[0] : 32'hx);
        end
    endtask

    task automatic test_multichannel();
        m_q.delete(); m_lq.delete();
        m_send(16'h0801); m_send(16'h0209); m_send(16'h0603); m_send(16'h0704);
        m_send(16'h00C8); m_send(16'hFF05); m_send(16'h0364); m_send(16'h0407);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (m_q.size() != 2) begin errors++; $display("FAIL mc_count got %0d want 2", m_q.size()); end
        if (m_q.size() == 2) begin
            checks++;
            if (m_q[0] !== 16'h0809) begin errors++; $display("FAIL mc_data0 got %h want 0809", m_q[0]); end
            checks++;
            if (m_q[1] !== 16'hFFC8) begin errors++; $display("FAIL mc_data1 got %h want ffc8", m_q[1]); end
            checks++;
            if (m_lq[0] !== 1'b1 || m_lq[1] !== 1'b1) begin errors++; $display("FAIL mc_last got %0b%0b want 11", m_lq[0], m_lq[1]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        a_q.delete(); a_lq.delete();
        a_out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 16; k++) a_send(32'(k));
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!a_out_valid && n < 100) begin @(negedge clk); n++; end
                checks++;
                if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_pending got %0b want 1", a_out_valid); end
                held = a_out_data;
                checks++;
                if (held !== 32'd5) begin errors++; $display("FAIL bp_first got %0d want 5", held); end
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    checks++;
                    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_data !== held) begin
                        errors++;
                        $display("FAIL bp_hold[%0d] got rdy %0b vld %0b data %0d want rdy 0 vld 1 data %0d",
                                 c, a_in_ready, a_out_valid, a_out_data, held);
                    end
                end
                @(posedge clk); #1;
                a_out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk); #1;
        checks++;
        if (a_q.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", a_q.size()); end
        for (int i = 0; i < 4 && i < a_q.size(); i++) begin
            checks++;
            if (a_q[i] !== RAMP_EXP[i] || a_lq[i] !== (i == 3)) begin
                errors++; $display("FAIL bp_data[%0d] got %0d/%0b want %0d/%0b", i, a_q[i], a_lq[i], RAMP_EXP[i], (i == 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        int lasts;
        int bad;
        b_q.delete(); b_lq.delete();
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 784; p++) begin
                logic [31:0] c0, c1;
                c0 = 32'(f * 4096 + p);
                c1 = 32'(1000 - p);
                b_send({c1, c0});
            end
        end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (b_q.size() != 392) begin errors++; $display("FAIL b2b_count got %0d want 392", b_q.size()); end
        lasts = 0;
        foreach (b_lq[k]) if (b_lq[k]) lasts++;
        checks++;
        if (lasts != 2) begin errors++; $display("FAIL b2b_last_pulses got %0d want 2", lasts); end
        if (b_q.size() == 392) begin
            checks++;
            if (b_lq[195] !== 1'b1 || b_lq[391] !== 1'b1) begin
                errors++; $display("FAIL b2b_last_pos got %0b/%0b want 1/1", b_lq[195], b_lq[391]);
            end
            bad = 0;
            for (int o = 0; o < 392; o++) begin
                int f, q, i, j;
                logic [31:0] e0, e1;
                f  = o / 196;
                q  = o % 196;
                i  = q / 14;
                j  = q % 14;
                e0 = 32'(f * 4096 + (2 * i + 1) * 28 + 2 * j + 1);
                e1 = 32'(1000 - (2 * i * 28 + 2 * j));
                checks++;
                if (b_q[o] !== {e1, e0}) begin
                    errors++;
                    if (bad < 5) $display("FAIL b2b_data[%0d] got %h want %h", o, b_q[o], {e1, e0});
                    bad++;
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        for (int k = 0; k < 37; k++) a_send(32'd100 + 32'(k));
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        a_q.delete(); a_lq.delete();
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_state got vld %0b rdy %0b want 0/1", a_out_valid, a_in_ready);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) a_send(32'(k));
        repeat (3) @(posedge clk); #1;
        checks++;
        if (a_q.size() != 4) begin errors++; $display("FAIL rstmid_count got %0d want 4", a_q.size()); end
        for (int i = 0; i < 4 && i < a_q.size(); i++) begin
            checks++;
            if (a_q[i] !== RAMP_EXP[i] || a_lq[i] !== (i == 3)) begin
                errors++; $display("FAIL rstmid_data[%0d] got %0d/%0b want %0d/%0b", i, a_q[i], a_lq[i], RAMP_EXP[i], (i == 3));
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        a_in_data   = '0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        s_in_data   = '0; s_in_valid = 1'b0; s_out_ready = 1'b1;
        m_in_data   = '0; m_in_valid = 1'b0; m_out_ready = 1'b1;
        b_in_data   = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;

        test_reset();
        test_ramp();
        test_gaps();
        test_signed();
        test_multichannel();
        test_backpressure();
        test_back_to_back();
        test_reset_midframe();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxpool_stream.md
MAXPOOL_STREAM -- requirements
Module: maxpool_stream

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32, meaning width of one feature value.
REQ-002 SHALL have parameter CHANNELS, default 2, meaning feature-map channels carried in parallel per beat.
REQ-003 SHALL have parameter IMG_W, default 28, meaning input columns per row; must be even and >= 2.
REQ-004 SHALL have parameter IMG_H, default 28, meaning input rows per frame; must be even and >= 2.
REQ-005 SHALL have parameter SIGNED_MODE, default 0, meaning compare two's-complement when 1 and unsigned when 0.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port in_data, input, CHANNELS*BITWIDTH, one pixel with channel c in bits [c*BITWIDTH +: BITWIDTH].
REQ-009 SHALL have port in_valid, input, 1, meaning in_data is valid.
REQ-010 SHALL have port in_ready, output, 1, meaning the block accepts in_data this cycle.
REQ-011 SHALL have port out_data, output, CHANNELS*BITWIDTH, one pooled pixel, same packing as in_data.
REQ-012 SHALL have port out_valid, output, 1, meaning out_data is valid.
REQ-013 SHALL have port out_ready, input, 1, meaning the downstream accepts out_data.
REQ-014 SHALL have port out_last, output, 1, meaning out_data is the final pooled pixel of a frame.

Function
REQ-015 Input SHALL be raster order, row-major, IMG_W*IMG_H beats per frame; a beat transfers when in_valid and in_ready are both high.
REQ-016 Output SHALL be 2x2 max pooling, stride 2: output (i,j) = per-channel max of input (2i,2j), (2i,2j+1), (2i+1,2j) and (2i+1,2j+1), emitted in raster order, (IMG_W/2)*(IMG_H/2) beats per frame.
REQ-017 Column counter SHALL run 0..IMG_W-1 and row counter 0..IMG_H-1, advancing only on accepted beats; both wrap to 0 after the last pixel of a frame, with no idle cycle required between frames.
REQ-018 On an even column the block SHALL store the pixel in a horizontal-hold register.
REQ-019 On an odd column of an even row it SHALL write max(hold, pixel) into line-buffer entry col/2, which has IMG_W/2 entries of CHANNELS*BITWIDTH bits.
REQ-020 On an odd column of an odd row it SHALL load max(line-buffer[col/2], hold, pixel) into the output register and set out_valid.
REQ-021 Latency SHALL be one cycle: out_valid rises on the cycle after the completing beat is accepted.
REQ-022 Comparisons SHALL be per channel, full BITWIDTH, signed when SIGNED_MODE=1 and unsigned otherwise; equal operands give that value; no width growth or saturation.
REQ-023 Output register SHALL be single-entry: out_data and out_last hold steady while out_valid is high and out_ready is low.
REQ-024 in_ready SHALL equal (!out_valid || out_ready); this allows back-to-back flow at one beat per cycle while out_ready is high.
REQ-025 When out_valid and out_ready are high and a new completing beat is accepted in the same cycle, the output register SHALL load the new value and keep out_valid high.
REQ-026 out_last SHALL be high only with the pooled pixel completed by input (IMG_H-1, IMG_W-1).
REQ-027 in_valid low SHALL not change any state except draining of the output register.

Reset
REQ-028 While rst is high at a clock edge, out_valid SHALL be 0, out_last 0, out_data all zeros, and the row counter, column counter and hold register 0.
REQ-029 in_ready SHALL be 1 in the cycle after reset; line-buffer contents need not be reset, because every entry is written before it is read.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame and any pending output; the next accepted beat is pixel (0,0) of a new frame.

Verification
REQ-031 Ramp test: CHANNELS=1, IMG_W=IMG_H=4, unsigned, inputs 0..15 in raster order with out_ready=1 -> outputs 5, 7, 13, 15, with out_last only on 15.
REQ-032 Signed test: SIGNED_MODE=1, 2x2 frame of -1, -5, -3, -2 (32'hFFFFFFFF, ...) -> output -1; the same frame with SIGNED_MODE=0 -> output 32'hFFFFFFFF, the largest unsigned value.
REQ-033 Multichannel test: CHANNELS=2, channel 0 inputs {1,9,3,4} and channel 1 inputs {8,2,6,7} -> out_data is channel 0 = 9, channel 1 = 8.
REQ-034 Backpressure test: hold out_ready=0 for 10 cycles while an output is pending -> in_ready is 0, out_data is stable and no beat is lost; releasing out_ready gives the same output sequence as REQ-031.
REQ-035 Back-to-back frames: two 28x28 frames streamed with no gap -> 196 outputs per frame and exactly two out_last pulses.
REQ-036 Reset test: rst asserted after 37 beats of a 4x4 frame, then a full frame is sent -> only that frame's 4 outputs appear, with correct values.
